// File: rtl/secam_decoder.sv
// SECAM chroma FM demodulator.
// Measures the subcarrier period by counting clocks across a fixed number of
// rising zero crossings. The deviation from the Db or Dr rest count becomes a
// signed U (Db lines) or V (Dr lines) value. Each output holds its value until
// it is next written, which gives the line-delay behaviour downstream needs.
module secam_decoder #(
   parameter int ACC_CYCLES = 8,
   parameter int DB_REF     = 90,
   parameter int DR_REF     = 87,
   parameter int GAIN_SHIFT = 2,
   parameter int HYST       = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic signed [7:0] chroma_in,
   input  logic              even_line,
   input  logic              line_start,
   input  logic              active,
   output logic signed [7:0] out_u,
   output logic signed [7:0] out_v,
   output logic              out_valid,
   output logic              carrier_present
);

   localparam int GAP_W = $clog2(TIMEOUT + 1);
   localparam int XW    = $clog2(ACC_CYCLES + 1);
   localparam int SH_W  = 13 + GAIN_SHIFT;

   localparam logic signed [7:0]      HYST_NEG = 8'(-HYST);
   localparam logic signed [12:0]     DB_REF_S = 13'(DB_REF);
   localparam logic signed [12:0]     DR_REF_S = 13'(DR_REF);
   localparam logic signed [SH_W-1:0] SAT_HI   = SH_W'(127);
   localparam logic signed [SH_W-1:0] SAT_LO   = SH_W'(-128);

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      MEASURE
   } state_t;

   state_t state, state_nxt;

   logic signed [7:0]      s0, s1;
   logic                   armed;
   logic                   cross_raw;
   logic                   cross_q;
   logic                   line_type;
   logic [11:0]            acc_cnt, acc_nxt, acc_sat;
   logic [GAP_W-1:0]       gap_cnt, gap_nxt;
   logic [XW-1:0]          xcnt, xcnt_nxt;
   logic signed [7:0]      u_nxt, v_nxt;
   logic                   valid_nxt;
   logic                   carrier_nxt;
   logic                   timeout;
   logic signed [12:0]     acc_ext;
   logic signed [12:0]     dev;
   logic signed [SH_W-1:0] dev_sh;
   logic signed [7:0]      dev_sat;

   // A rising crossing needs the detector to have been armed by a clearly negative sample.
   assign cross_raw = (s1 < 8'sd0) && (s0 >= 8'sd0) && armed;

   // Input pipeline, hysteresis arming, and a registered crossing strobe for the FSM.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s0      <= '0;
         s1      <= '0;
         armed   <= 1'b0;
         cross_q <= 1'b0;
      end else begin
         s0      <= chroma_in;
         s1      <= s0;
         cross_q <= cross_raw;
         if (cross_raw)
            armed <= 1'b0;
         else if (s0 <= HYST_NEG)
            armed <= 1'b1;
      end
   end

   // Latch the line type at every line start, whatever the measurement state.
   always_ff @(posedge clk) begin
      if (!rst_n)
         line_type <= 1'b0;
      else if (line_start)
         line_type <= even_line;
   end

   // Window length including the current clock, then deviation, gain and saturation.
   always_comb begin
      acc_sat = (acc_cnt == 12'hFFF) ? acc_cnt : acc_cnt + 12'd1;
      acc_ext = $signed({1'b0, acc_sat});
      dev     = line_type ? (DB_REF_S - acc_ext) : (acc_ext - DR_REF_S);
      dev_sh  = SH_W'(dev) <<< GAIN_SHIFT;
      if (dev_sh > SAT_HI)
         dev_sat = 8'sd127;
      else if (dev_sh < SAT_LO)
         dev_sat = -8'sd128;
      else
         dev_sat = dev_sh[7:0];
   end

   // Next-state and output decisions; line_start beats a crossing, a crossing beats timeout.
   always_comb begin
      state_nxt   = state;
      acc_nxt     = acc_cnt;
      gap_nxt     = gap_cnt;
      xcnt_nxt    = xcnt;
      u_nxt       = out_u;
      v_nxt       = out_v;
      valid_nxt   = 1'b0;
      carrier_nxt = carrier_present;
      timeout     = 1'b0;
      case (state)
         IDLE: begin
            acc_nxt  = '0;
            gap_nxt  = '0;
            xcnt_nxt = '0;
            if (active)
               state_nxt = SYNC;
         end
         SYNC, MEASURE: begin
            if (!active) begin
               state_nxt = IDLE;
               acc_nxt   = '0;
               gap_nxt   = '0;
               xcnt_nxt  = '0;
            end else begin
               timeout = !cross_q && (gap_cnt == GAP_W'(TIMEOUT - 1));
               if (cross_q)
                  gap_nxt = '0;
               else if (gap_cnt != GAP_W'(TIMEOUT))
                  gap_nxt = gap_cnt + GAP_W'(1);
               if (state == MEASURE)
                  acc_nxt = acc_sat;
               if (line_start) begin
                  state_nxt = SYNC;
               end else if (cross_q) begin
                  if (state == SYNC) begin
                     state_nxt = MEASURE;
                     acc_nxt   = '0;
                     xcnt_nxt  = '0;
                  end else if (xcnt == XW'(ACC_CYCLES - 1)) begin
                     // The completing crossing also opens the next window, so the
                     // count restarts from the same point as a fresh start out of SYNC.
                     xcnt_nxt    = '0;
                     acc_nxt     = '0;
                     valid_nxt   = 1'b1;
                     carrier_nxt = 1'b1;
                     if (line_type)
                        u_nxt = dev_sat;
                     else
                        v_nxt = dev_sat;
                  end else begin
                     xcnt_nxt = xcnt + XW'(1);
                  end
               end
               if (timeout) begin
                  state_nxt   = SYNC;
                  carrier_nxt = 1'b0;
                  valid_nxt   = 1'b1;
                  if (line_type)
                     u_nxt = '0;
                  else
                     v_nxt = '0;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, counters and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= IDLE;
         acc_cnt         <= '0;
         gap_cnt         <= '0;
         xcnt            <= '0;
         out_u           <= '0;
         out_v           <= '0;
         out_valid       <= 1'b0;
         carrier_present <= 1'b0;
      end else begin
         state           <= state_nxt;
         acc_cnt         <= acc_nxt;
         gap_cnt         <= gap_nxt;
         xcnt            <= xcnt_nxt;
         out_u           <= u_nxt;
         out_v           <= v_nxt;
         out_valid       <= valid_nxt;
         carrier_present <= carrier_nxt;
      end
   end

endmodule

// File: tb/tb_secam_decoder.sv
// Testbench for secam_decoder: square-wave carriers with randomized phase,
// noise and control events. A timestamp-based reference model predicts every
// output on every clock.
module tb_secam_decoder;

   localparam int ACC_CYCLES = 8;
   localparam int DB_REF     = 90;
   localparam int DR_REF     = 87;
   localparam int GAIN_SHIFT = 2;
   localparam int HYST       = 4;
   localparam int TIMEOUT    = 64;

   localparam int M_OFF  = 0;
   localparam int M_HUNT = 1;
   localparam int M_MEAS = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic signed [7:0] chroma_in;
   logic              even_line;
   logic              line_start;
   logic              active;
   logic signed [7:0] out_u;
   logic signed [7:0] out_v;
   logic              out_valid;
   logic              carrier_present;

   int checks   = 0;
   int failures = 0;

   // Reference model state: sample history, crossing delay, and window timestamps.
   int cyc       = 0;
   int mPrev     = 0;
   int mode      = M_OFF;
   int lastCross = 0;
   int winStart  = 0;
   int nCross    = 0;
   int expU      = 0;
   int expV      = 0;
   bit mArm      = 1'b0;
   bit dly0      = 1'b0;
   bit dly1      = 1'b0;
   bit lineEven  = 1'b0;
   bit expValid  = 1'b0;
   bit expCarrier = 1'b0;
   bit primed    = 1'b0;

   // Free-running clock.
   always #5 clk = ~clk;

   secam_decoder #(
      .ACC_CYCLES (ACC_CYCLES),
      .DB_REF     (DB_REF),
      .DR_REF     (DR_REF),
      .GAIN_SHIFT (GAIN_SHIFT),
      .HYST       (HYST),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .chroma_in       (chroma_in),
      .even_line       (even_line),
      .line_start      (line_start),
      .active          (active),
      .out_u           (out_u),
      .out_v           (out_v),
      .out_valid       (out_valid),
      .carrier_present (carrier_present)
   );

   // Every comparison goes through here.
   task automatic checkOutput(input string tag, input logic signed [15:0] observed,
                              input logic signed [15:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         if (failures <= 40)
            $display("[TB] FAIL %s at cycle %0d: observed %0d, expected %0d",
                     tag, cyc, observed, expected);
      end
   endtask

   // Demodulated value for a window of span clocks, straight from the arithmetic rule.
   function automatic int expectResult(input int span, input bit even);
      int s;
      int d;
      int v;
      s = (span > 4095) ? 4095 : span;
      d = even ? (DB_REF - s) : (s - DR_REF);
      v = d * (2 ** GAIN_SHIFT);
      if (v > 127)  v = 127;
      if (v < -128) v = -128;
      return v;
   endfunction

   // Advance the model by one clock edge given the inputs presented to it.
   task automatic modelEdge(input int x, input bit ev, input bit ls, input bit act, input bit rstn);
      bit c;
      bit newCross;
      bit tmo;
      bit oldEven;
      int r;
      cyc++;
      if (!rstn) begin
         mPrev = 0; mArm = 0; dly0 = 0; dly1 = 0;
         mode = M_OFF; lastCross = cyc; winStart = cyc; nCross = 0;
         lineEven = 0; expU = 0; expV = 0; expValid = 0; expCarrier = 0;
         return;
      end
      // A crossing found on a sample acts on the decoder two edges later.
      c        = dly1;
      dly1     = dly0;
      newCross = (mPrev < 0) && (x >= 0) && mArm;
      if (newCross) mArm = 0;
      if (x <= -HYST) mArm = 1;
      mPrev    = x;
      dly0     = newCross;

      expValid = 0;
      oldEven  = lineEven;
      if (mode == M_OFF) begin
         if (act) begin
            mode      = M_HUNT;
            lastCross = cyc;
         end
      end else if (!act) begin
         mode = M_OFF;
      end else begin
         tmo = !c && ((cyc - lastCross) == TIMEOUT);
         if (c) lastCross = cyc;
         if (ls) begin
            mode = M_HUNT;
         end else if (c && mode == M_HUNT) begin
            mode     = M_MEAS;
            winStart = cyc;
            nCross   = 0;
         end else if (c) begin
            nCross++;
            if (nCross == ACC_CYCLES) begin
               r = expectResult(cyc - winStart, oldEven);
               if (oldEven) expU = r; else expV = r;
               expValid   = 1;
               expCarrier = 1;
               winStart   = cyc;
               nCross     = 0;
            end
         end
         if (tmo) begin
            expCarrier = 0;
            expValid   = 1;
            if (oldEven) expU = 0; else expV = 0;
            mode = M_HUNT;
         end
      end
      if (ls) lineEven = ev;
   endtask

   // One clock: check the outputs of the previous edge, drive new inputs, step the model.
   task automatic stepCycle(input logic signed [7:0] x, input bit ev, input bit ls,
                            input bit act, input bit rstn);
      @(negedge clk);
      if (primed) begin
         checkOutput("out_u", 16'(out_u), 16'(expU));
         checkOutput("out_v", 16'(out_v), 16'(expV));
         checkOutput("out_valid", 16'(out_valid), 16'(expValid));
         checkOutput("carrier_present", 16'(carrier_present), 16'(expCarrier));
      end
      chroma_in  = x;
      even_line  = ev;
      line_start = ls;
      active     = act;
      rst_n      = rstn;
      modelEdge(int'(x), ev, ls, act, rstn);
      primed = 1'b1;
   endtask

   // A stretch of square-wave carrier (period 0 means a flat zero input) with control events.
   task automatic applyStimulus(input int period, input int amp, input bit ev, input int cycles,
                                input bit noise, input bit lsStart, input int midLs,
                                input bit aim, input bit act, input int rstAt);
      int phase;
      phase = (period > 0) ? int'($urandom_range(0, period - 1)) : 0;
      for (int i = 0; i < cycles; i++) begin
         int base;
         int x;
         bit ls;
         if (period == 0)
            base = 0;
         else
            base = (((phase + i) % period) < (period / 2)) ? -amp : amp;
         x  = base + (noise ? (int'($urandom_range(0, 2)) - 1) : 0);
         ls = (lsStart && i == 0) || (i == midLs);
         if (aim && act && dly1 && mode == M_MEAS && nCross == ACC_CYCLES - 1)
            ls = 1'b1;
         stepCycle(8'(x), ev, ls, act, !(i == rstAt));
      end
   endtask

   // Directed scenarios with fixed expected values, then randomized segments.
   initial begin
      for (int i = 0; i < 3; i++)
         stepCycle(8'sd0, 1'b0, 1'b0, 1'b0, 1'b0);

      applyStimulus(11, 40, 1'b1, 220, 1'b0, 1'b1, -1, 1'b0, 1'b1, -1);
      checkOutput("rest_db_u", 16'(out_u), 16'sd8);
      checkOutput("rest_db_v", 16'(out_v), 16'sd0);
      checkOutput("rest_db_carrier", 16'(carrier_present), 16'sd1);

      applyStimulus(10, 40, 1'b0, 300, 1'b0, 1'b1, -1, 1'b0, 1'b1, -1);
      checkOutput("dr_p10_v", 16'(out_v), -16'sd28);
      checkOutput("dr_p10_u_hold", 16'(out_u), 16'sd8);

      applyStimulus(12, 40, 1'b1, 300, 1'b0, 1'b1, -1, 1'b0, 1'b1, -1);
      checkOutput("db_p12_u", 16'(out_u), -16'sd24);

      applyStimulus(40, 40, 1'b1, 1000, 1'b0, 1'b1, -1, 1'b0, 1'b1, -1);
      checkOutput("db_sat_u", 16'(out_u), -16'sd128);

      applyStimulus(3, 40, 1'b0, 120, 1'b0, 1'b1, -1, 1'b0, 1'b1, -1);
      checkOutput("dr_sat_v", 16'(out_v), -16'sd128);

      applyStimulus(11, 40, 1'b1, 250, 1'b0, 1'b1, -1, 1'b0, 1'b1, -1);
      applyStimulus(0, 0, 1'b1, 120, 1'b0, 1'b0, -1, 1'b0, 1'b1, -1);
      checkOutput("loss_carrier", 16'(carrier_present), 16'sd0);
      checkOutput("loss_u", 16'(out_u), 16'sd0);

      applyStimulus(11, 40, 1'b1, 150, 1'b0, 1'b0, -1, 1'b0, 1'b1, -1);
      checkOutput("resume_carrier", 16'(carrier_present), 16'sd1);
      checkOutput("resume_u", 16'(out_u), 16'sd8);

      applyStimulus(11, 2, 1'b1, 150, 1'b0, 1'b1, -1, 1'b0, 1'b1, -1);
      checkOutput("small_amp_carrier", 16'(carrier_present), 16'sd0);
      checkOutput("small_amp_u", 16'(out_u), 16'sd0);

      applyStimulus(11, 40, 1'b1, 300, 1'b1, 1'b1, -1, 1'b0, 1'b1, -1);
      checkOutput("noisy_u", 16'(out_u), 16'sd8);

      applyStimulus(11, 40, 1'b1, 400, 1'b0, 1'b1, 150, 1'b0, 1'b1, -1);
      checkOutput("mid_line_start_u", 16'(out_u), 16'sd8);

      applyStimulus(11, 40, 1'b1, 60, 1'b0, 1'b0, -1, 1'b0, 1'b0, -1);
      checkOutput("inactive_u_hold", 16'(out_u), 16'sd8);
      checkOutput("inactive_carrier_hold", 16'(carrier_present), 16'sd1);

      applyStimulus(11, 40, 1'b1, 200, 1'b0, 1'b1, -1, 1'b0, 1'b1, 150);
      checkOutput("after_reset_u", 16'(out_u), 16'sd0);
      checkOutput("after_reset_carrier", 16'(carrier_present), 16'sd0);

      applyStimulus(11, 40, 1'b1, 600, 1'b0, 1'b1, -1, 1'b1, 1'b1, -1);
      checkOutput("coincident_u", 16'(out_u), 16'sd0);
      checkOutput("coincident_carrier", 16'(carrier_present), 16'sd0);

      for (int seg = 0; seg < 25; seg++) begin
         int period;
         int amp;
         int cycles;
         int midLs;
         int rstAt;
         period = int'($urandom_range(3, 80));
         case ($urandom_range(0, 4))
            0:       amp = 2;
            1:       amp = 10;
            2:       amp = 100;
            default: amp = 40;
         endcase
         cycles = int'($urandom_range(150, 700));
         midLs  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, cycles - 1)) : -1;
         rstAt  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, cycles - 1)) : -1;
         applyStimulus(period, amp, 1'($urandom_range(0, 1)), cycles,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), midLs,
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) != 0), rstAt);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
